branch_predictor_btb: RTL
=========================

Name: branch_predictor_btb

Overview:
- Direct-mapped branch target buffer with 2-bit saturating-counter direction prediction.
- Fetch side: combinational taken/target prediction for the current PC.
- Resolve side: consumes the branch resolution result (taken, target) one stage downstream of the fetch PC. Updates the tables, detects mispredicts, issues a registered redirect to fetch and keeps saturating performance counters.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, >= 2.
- WORD_SIZE, 32, address width; taken from rv32i_types_pkg.

Ports:
- CLK  input  1  core clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- fetch_pc  input  WORD_SIZE  PC of the instruction being fetched.
- predict_taken  output  1  prediction for fetch_pc: taken.
- predict_target  output  WORD_SIZE  predicted next PC; fetch_pc+4 when not taken.
- update_valid  input  1  a resolved conditional branch is presented this cycle.
- update_pc  input  WORD_SIZE  PC of the resolved branch.
- update_taken  input  1  resolved direction (branch_taken).
- update_target  input  WORD_SIZE  resolved target (branch_addr).
- update_pred_taken  input  1  prediction originally made for this branch, carried down the pipe.
- update_pred_target  input  WORD_SIZE  target originally predicted.
- redirect_valid  output  1  registered: fetch must restart at redirect_pc.
- redirect_pc  output  WORD_SIZE  correct next PC after a mispredict.
- stats_clear  input  1  synchronous clear of the performance counters.
- branch_count  output  32  resolved branches; saturating.
- mispredict_count  output  32  mispredicts; saturating.

Behaviour:
- Indexing:
  - idx = pc[IDX_W+1:2], where IDX_W = $clog2(ENTRIES).
  - tag = pc[WORD_SIZE-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target[WORD_SIZE-1:0], ctr[1:0].
- Reset (nRST low, asynchronous): all valid=0, all ctr=2'b01, redirect_valid=0, redirect_pc=0, both counters=0.
- Prediction (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - predict_taken = hit & ctr[1].
  - predict_target = entry target if predict_taken, else fetch_pc+4 (wraps modulo 2^WORD_SIZE).
- Update, on a rising edge with update_valid=1:
  - Hit, taken: ctr increments, saturating at 2'b11; target overwritten with update_target.
  - Hit, not taken: ctr decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate/replace the entry: valid=1, tag=update tag, target=update_target, ctr=2'b10.
  - Miss, not taken: no table change.
- Read/write collision (same index in the same cycle): the prediction reflects the old contents. No bypass.
- Mispredict (combinational internal):
  - mispredict = update_valid & ((update_pred_taken != update_taken) | (update_taken & update_pred_target != update_target)).
- Redirect (registered, one-cycle latency):
  - On the edge, redirect_valid <= mispredict.
  - If mispredict: redirect_pc <= update_taken ? update_target : update_pc+4. Otherwise redirect_pc holds.
  - redirect_valid is a single-cycle pulse per mispredict. Back-to-back mispredicts give back-to-back pulses.
- Counters:
  - branch_count += update_valid.
  - mispredict_count += mispredict.
  - Each holds at 32'hFFFF_FFFF.
  - stats_clear has priority over a same-cycle increment; both counters become 0.
- Reset mid-operation: all state returns immediately to reset values, including an in-flight redirect.
- update_valid=0: the tables, counters and redirect_pc are unchanged; redirect_valid is 0 on the next cycle.

Decomposition:
- Add to rv32i_types_pkg:
  - btb_entry_t struct (valid, tag, target, ctr).
  - Counter encoding constants: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
- Add a predictor_update_if interface bundling the update_* signals, so branch resolution drives it directly.
- One natural sub-module: sat_counter2, the 2-bit saturating up/down next-state function, used per update.
- Tables stay in flops in the top module; no SRAM macro at this size.

Test Plan:
- Reset, then fetch_pc=0x100 -> predict_taken=0, predict_target=0x104; counters 0, redirect_valid=0.
- First resolve: update_pc=0x100, taken=1, target=0x80, pred_taken=0:
  - next cycle redirect_valid=1, redirect_pc=0x80, mispredict_count=1, branch_count=1;
  - fetch_pc=0x100 then predicts taken, target 0x80 (ctr=10).
- Hysteresis: train 0x100 taken twice more (ctr=11), then resolve not-taken once with pred_taken=1:
  - redirect to 0x104;
  - the prediction for 0x100 remains taken (ctr=10).
- Aliasing (ENTRIES=16): with 0x100 trained, resolve 0x140 (same idx, different tag) taken to 0x200:
  - the entry is replaced;
  - fetch 0x100 -> not taken, 0x104;
  - fetch 0x140 -> taken, 0x200.
- Target-only mispredict: pred_taken=1, pred_target=0x80, actual taken to 0x90 -> redirect_pc=0x90, entry target updated to 0x90.
- Counter saturation and clear:
  - force branch_count=32'hFFFF_FFFF, resolve -> holds;
  - stats_clear together with update_valid -> both counters 0;
  - nRST asserted during a redirect cycle -> redirect_valid drops immediately.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared core types: word width, BTB entry layout and 2-bit direction counter encodings.
package rv32i_types_pkg;
  localparam int WORD_SIZE = 32;

  typedef logic [WORD_SIZE-1:0] word_t;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Tag kept word-wide and zero-extended so the layout is independent of ENTRIES;
  // the constant-zero upper bits are pruned in synthesis.
  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    logic [1:0] ctr;
  } btb_entry_t;
endpackage

// File: rtl/predictor_update_if.sv
// Branch resolution result bundle, driven by the resolve stage into the predictor.
interface predictor_update_if;
  import rv32i_types_pkg::*;
  logic  valid;
  word_t pc;
  logic  taken;
  word_t target;
  logic  pred_taken;
  word_t pred_target;

  modport resolve (output valid, pc, taken, target, pred_taken, pred_target);
  modport btb     (input  valid, pc, taken, target, pred_taken, pred_target);
endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state function.
module sat_counter2
  import rv32i_types_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] next
);
  always_comb begin
    next = ctr;
    if (up) begin
      if (ctr != STRONG_T) next = ctr + 2'd1;
    end else begin
      if (ctr != STRONG_NT) next = ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters, registered mispredict redirect
// and saturating branch/mispredict performance counters.
module branch_predictor_btb
  import rv32i_types_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       fetch_pc,
  output logic        predict_taken,
  output word_t       predict_target,
  input  logic        update_valid,
  input  word_t       update_pc,
  input  logic        update_taken,
  input  word_t       update_target,
  input  logic        update_pred_taken,
  input  word_t       update_pred_target,
  output logic        redirect_valid,
  output word_t       redirect_pc,
  input  logic        stats_clear,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);
  localparam int IDX_W = $clog2(ENTRIES);

  predictor_update_if upd ();
  assign upd.valid       = update_valid;
  assign upd.pc          = update_pc;
  assign upd.taken       = update_taken;
  assign upd.target      = update_target;
  assign upd.pred_taken  = update_pred_taken;
  assign upd.pred_target = update_pred_target;

  btb_entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  word_t            f_tag, u_tag;
  logic             f_hit, u_hit, mispredict;
  logic [1:0]       ctr_next;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign u_idx = upd.pc[IDX_W+1:2];
  assign f_tag = fetch_pc >> (IDX_W + 2);
  assign u_tag = upd.pc >> (IDX_W + 2);

  // Prediction reads the pre-edge table: a same-index update is not bypassed.
  assign f_hit          = tbl[f_idx].valid && (tbl[f_idx].tag == f_tag);
  assign predict_taken  = f_hit && tbl[f_idx].ctr[1];
  assign predict_target = predict_taken ? tbl[f_idx].target : fetch_pc + 32'd4;

  assign u_hit      = tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);
  assign mispredict = upd.valid &&
                      ((upd.pred_taken != upd.taken) ||
                       (upd.taken && (upd.pred_target != upd.target)));

  sat_counter2 u_ctr (
    .ctr  (tbl[u_idx].ctr),
    .up   (upd.taken),
    .next (ctr_next)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
    end else if (upd.valid) begin
      if (u_hit) begin
        tbl[u_idx].ctr <= ctr_next;
        if (upd.taken) tbl[u_idx].target <= upd.target;
      end else if (upd.taken) begin
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd.target, ctr: WEAK_T};
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= upd.taken ? upd.target : upd.pc + 32'd4;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (stats_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (upd.valid && (branch_count != '1))   branch_count     <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != '1)) mispredict_count <= mispredict_count + 32'd1;
    end
  end
endmodule
